// File: rtl/comunicaciones_pkg.sv
// ============================================================================
// comunicaciones_pkg : constants and types shared by the modem UART blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package comunicaciones_pkg;

  // Clocks per bit at 50 MHz; the AT-command sender uses the same table.
  localparam int B115200 = 434;
  localparam int B57600  = 868;
  localparam int B38400  = 1302;
  localparam int B19200  = 2604;
  localparam int B9600   = 5208;
  localparam int B4800   = 10417;
  localparam int B2400   = 20833;
  localparam int B1200   = 41667;
  localparam int B600    = 83333;
  localparam int B300    = 166667;

  localparam logic [2:0] RESP_NONE     = 3'd0;
  localparam logic [2:0] RESP_OK       = 3'd1;
  localparam logic [2:0] RESP_ERROR    = 3'd2;
  localparam logic [2:0] RESP_PROMPT   = 3'd3;
  localparam logic [2:0] RESP_RING     = 3'd4;
  localparam logic [2:0] RESP_OTHER    = 3'd5;
  localparam logic [2:0] RESP_OVERFLOW = 3'd6;

  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] PROMPT = 8'h3E;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_RECV   = 2'd1,
    P_MATCH  = 2'd2,
    P_REPORT = 2'd3
  } parse_state_t;

endpackage

`default_nettype wire

// File: rtl/comunicaciones_rx_uart_rx.sv
// ============================================================================
// uart_rx : 8N1 deserialiser with mid-bit sampling and stop-bit check
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import comunicaciones_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(BAUD);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(BAUD - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = '0;

  uart_state_t      state_q, state_d;
  logic             meta_q, sync_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= U_IDLE;
      cnt_q   <= ZERO_C;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = U_START;
          cnt_d   = HALF_C;
        end
      end
      U_START: begin
        if (cnt_q != ZERO_C) begin
          cnt_d = cnt_q - ONE_C;
        end else if (sync_q) begin
          // Glitch rather than a real start bit.
          state_d = U_IDLE;
        end else begin
          state_d = U_DATA;
          cnt_d   = FULL_C;
          bit_d   = 3'd0;
        end
      end
      U_DATA: begin
        if (cnt_q != ZERO_C) begin
          cnt_d = cnt_q - ONE_C;
        end else begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = FULL_C;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end
      end
      U_STOP: begin
        if (cnt_q != ZERO_C) begin
          cnt_d = cnt_q - ONE_C;
        end else begin
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~sync_q;
          state_d = U_IDLE;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

`default_nettype wire

// File: rtl/comunicaciones_rx.sv
// ============================================================================
// comunicaciones_rx : modem response receiver, line buffer and classifier
// Revision: 1.0
// ============================================================================
`default_nettype none

module comunicaciones_rx
  import comunicaciones_pkg::*;
#(
  parameter int          BAUD     = B115200,
  parameter int          LINE_MAX = 16,
  parameter logic [27:0] TIMEOUT  = 28'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [2:0] resp_code,
  output logic       resp_valid,
  input  logic       resp_ack,
  output logic       resp_overrun,
  output logic       line_busy
);

  localparam int LEN_W = $clog2(LINE_MAX + 1);
  localparam int IDX_W = $clog2(LINE_MAX);
  localparam logic [LEN_W-1:0] LEN_MAX_C = LEN_W'(LINE_MAX);
  localparam logic [LEN_W-1:0] LEN_ONE_C = LEN_W'(1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ferr;

  uart_rx #(
    .BAUD(BAUD)
  ) u_uart_rx (
    .clk      (clk),
    .rstn     (rst),
    .rx       (rx),
    .data     (byte_data),
    .valid    (byte_valid),
    .frame_err(byte_ferr)
  );

  parse_state_t     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [2:0]       code_q, code_d;
  logic [27:0]      timer_q, timer_d;
  logic [7:0]       line_q [LINE_MAX];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= P_IDLE;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      code_q  <= RESP_NONE;
      timer_q <= 28'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      code_q  <= code_d;
      timer_q <= timer_d;
    end
  end

  // Storage needs no reset: only entries below len_q are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) line_q[wr_idx] <= byte_data;
  end

  logic is_ok, is_error, is_ring;
  assign is_ok    = (len_q == LEN_W'(2)) && (line_q[0] == "O") && (line_q[1] == "K");
  assign is_error = (len_q == LEN_W'(5)) && (line_q[0] == "E") && (line_q[1] == "R")
                  && (line_q[2] == "R") && (line_q[3] == "O") && (line_q[4] == "R");
  assign is_ring  = (len_q == LEN_W'(4)) && (line_q[0] == "R") && (line_q[1] == "I")
                  && (line_q[2] == "N") && (line_q[3] == "G");

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    code_d  = code_q;
    wr_en   = 1'b0;
    wr_idx  = len_q[IDX_W-1:0];
    if (byte_valid)              timer_d = TIMEOUT;
    else if (timer_q != 28'd0)   timer_d = timer_q - 28'd1;
    else                         timer_d = 28'd0;

    case (state_q)
      P_IDLE: begin
        if (byte_valid) begin
          if (byte_ferr) begin
            bad_d   = 1'b1;
            state_d = P_RECV;
          end else if (byte_data == PROMPT) begin
            // The modem sends '>' without a trailing LF.
            code_d  = RESP_PROMPT;
            ovr_d   = pend_q;
            pend_d  = 1'b0;
            state_d = P_REPORT;
          end else if (byte_data != CR && byte_data != LF) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            len_d   = LEN_ONE_C;
            state_d = P_RECV;
          end
        end
      end
      P_RECV: begin
        if (byte_valid) begin
          if (byte_ferr) begin
            bad_d = 1'b1;
          end else if (byte_data == LF) begin
            state_d = P_MATCH;
          end else if (byte_data != CR) begin
            if (len_q < LEN_MAX_C) begin
              wr_en = 1'b1;
              len_d = len_q + LEN_ONE_C;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (timer_q == 28'd0) begin
          len_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          state_d = P_IDLE;
        end
      end
      P_MATCH: begin
        if (ovf_q)         code_d = RESP_OVERFLOW;
        else if (bad_q)    code_d = RESP_OTHER;
        else if (is_ok)    code_d = RESP_OK;
        else if (is_error) code_d = RESP_ERROR;
        else if (is_ring)  code_d = RESP_RING;
        else               code_d = RESP_OTHER;
        ovr_d   = pend_q;
        pend_d  = 1'b0;
        state_d = P_REPORT;
      end
      P_REPORT: begin
        if (byte_valid) pend_d = 1'b1;
        if (resp_ack) begin
          code_d  = RESP_NONE;
          ovr_d   = 1'b0;
          len_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          state_d = P_IDLE;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign resp_valid   = (state_q == P_REPORT);
  assign resp_code    = code_q;
  assign resp_overrun = ovr_q;
  assign line_busy    = (state_q == P_RECV);

endmodule

`default_nettype wire

// File: tb/tb_comunicaciones_rx.sv
// ============================================================================
// tb_comunicaciones_rx : directed self-checking bench for comunicaciones_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comunicaciones_rx;

  localparam int          BAUD     = 32;
  localparam int          LINE_MAX = 16;
  localparam logic [27:0] TIMEOUT  = 28'd1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       resp_ack = 1'b0;
  logic [2:0] resp_code;
  logic       resp_valid;
  logic       resp_overrun;
  logic       line_busy;

  always #5 clk = ~clk;

  comunicaciones_rx #(
    .BAUD    (BAUD),
    .LINE_MAX(LINE_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .resp_code   (resp_code),
    .resp_valid  (resp_valid),
    .resp_ack    (resp_ack),
    .resp_overrun(resp_overrun),
    .line_busy   (line_busy)
  );

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_bv = 0;
  int   last_rise = 0;
  int   rises = 0;
  int   r0;
  logic prev_rv = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Timestamps of the last received byte and of each rising resp_valid.
  always @(negedge clk) begin
    if (dut.byte_valid) last_bv = cyc;
    if (resp_valid && !prev_rv) begin
      last_rise = cyc;
      rises = rises + 1;
    end
    prev_rv = resp_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic do_ack(input string tag);
    chk({tag, " valid before ack"}, resp_valid, 1);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    chk({tag, " valid after ack"}, resp_valid, 0);
    chk({tag, " code after ack"}, resp_code, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset code", resp_code, 0);
    chk("reset valid", resp_valid, 0);
    chk("reset overrun", resp_overrun, 0);
    chk("reset busy", line_busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Plain OK with latency check.
    send_str("OK\r\n");
    chk("ok latency", last_rise - last_bv, 2);
    chk("ok code", resp_code, 1);
    chk("ok overrun", resp_overrun, 0);
    do_ack("ok");

    // Ack while nothing is pending has no effect.
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    chk("idle ack valid", resp_valid, 0);

    // Empty line ignored, then ERROR.
    r0 = rises;
    send_str("\r\nERROR\r\n");
    chk("error report count", rises - r0, 1);
    chk("error code", resp_code, 2);
    do_ack("error");

    // Prompt without LF.
    send_byte(8'h3E, 1'b1);
    chk("prompt latency", last_rise - last_bv, 1);
    chk("prompt code", resp_code, 3);
    do_ack("prompt");

    // Overflowing line, then a normal RING.
    send_byte("A", 1'b1);
    chk("busy during line", line_busy, 1);
    for (int i = 0; i < 19; i++) send_byte("A", 1'b1);
    send_str("\r\n");
    chk("overflow code", resp_code, 6);
    do_ack("overflow");
    send_str("RING\r\n");
    chk("ring code", resp_code, 4);
    chk("ring overrun", resp_overrun, 0);
    do_ack("ring");

    // Second line arrives while first report is unacknowledged.
    r0 = rises;
    send_str("OK\r\nOK\r\n");
    chk("held report count", rises - r0, 1);
    chk("held code", resp_code, 1);
    chk("held overrun", resp_overrun, 0);
    do_ack("held");
    send_str("RING\r\n");
    chk("overrun ring code", resp_code, 4);
    chk("overrun flag", resp_overrun, 1);
    do_ack("overrun");
    chk("overrun cleared", resp_overrun, 0);

    // Partial line discarded by the idle timeout.
    r0 = rises;
    send_str("OK");
    chk("timeout busy before", line_busy, 1);
    repeat (1100) @(negedge clk);
    chk("timeout busy after", line_busy, 0);
    chk("timeout no report", rises - r0, 0);
    send_str("RING\r\n");
    chk("after timeout code", resp_code, 4);
    do_ack("after timeout");

    // Framing error inside a line.
    send_byte("O", 1'b1);
    send_byte("K", 1'b0);
    send_str("\r\n");
    chk("frame error code", resp_code, 5);
    do_ack("frame error");

    // Reset while a report is pending and a byte is in flight.
    send_byte(8'h3E, 1'b1);
    send_byte("X", 1'b1);
    chk("pre-reset valid", resp_valid, 1);
    rx = 1'b0;
    repeat (BAUD * 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset mid-byte valid", resp_valid, 0);
    chk("reset mid-byte code", resp_code, 0);
    chk("reset mid-byte overrun", resp_overrun, 0);
    rx = 1'b1;
    repeat (BAUD * 2) @(negedge clk);
    rst = 1'b1;
    repeat (BAUD) @(negedge clk);
    send_byte(8'h3E, 1'b1);
    chk("post-reset prompt code", resp_code, 3);
    chk("post-reset overrun", resp_overrun, 0);
    do_ack("post-reset prompt");

    // Reset while a line is being collected.
    send_byte("A", 1'b1);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset mid-line busy", line_busy, 0);
    rx = 1'b1;
    repeat (BAUD * 2) @(negedge clk);
    rst = 1'b1;
    repeat (BAUD) @(negedge clk);
    send_str("OK\r\n");
    chk("post-reset ok code", resp_code, 1);
    do_ack("post-reset ok");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/comunicaciones_rx.md
# comunicaciones_rx

Receive-side counterpart of the AT-command sender. The block deserialises the modem's UART response stream and buffers one line at a time, terminated by LF (0x0A). It classifies each line against a fixed response set and reports a 3-bit response code to the J1 SoC control logic with a valid/ack handshake. It connects to the same modem port whose TX pin carries the command strings.

## Interface
Parameters:
- BAUD, 434: clocks per bit; 50 MHz clock gives 115200 baud. Same constant set as the sender (`B115200` … `B300`).
- LINE_MAX, 16: line buffer depth in bytes, CR excluded.
- TIMEOUT, 28'd5_000_000: idle clocks (100 ms) before a partial line is discarded.

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst, in, 1: synchronous, active-low reset.
- rx, in, 1: serial input from the modem. Asynchronous; idles high.
- resp_code, out, 3: 0 NONE, 1 OK, 2 ERROR, 3 PROMPT, 4 RING, 5 OTHER, 6 OVERFLOW.
- resp_valid, out, 1: high while a response is pending.
- resp_ack, in, 1: consumer acknowledge.
- resp_overrun, out, 1: bytes were dropped while the previous response was pending. Valid together with resp_valid.
- line_busy, out, 1: a partial line is being collected.

## Operation
- Reset values: resp_code=0, resp_valid=0, resp_overrun=0, line_busy=0. Buffer length is 0. The rx synchroniser is loaded with 1.
- uart_rx sub-module:
  - 2-FF synchroniser on rx.
  - A falling edge starts the bit counter. The start bit is re-checked at BAUD/2; if it is high there, the block returns to idle.
  - Data bits are sampled every BAUD cycles at mid-bit, LSB first.
  - At mid-stop it emits a 1-cycle pulse on byte_valid with byte_data, and sets frame_err if the stop bit is 0.
- Parser state machine:
  - **IDLE**:
    - CR is ignored.
    - LF is ignored (empty line).
    - '>' (0x3E) → REPORT with PROMPT. No LF follows the modem prompt.
    - Any other byte → store it, length=1, go to RECV.
  - **RECV**:
    - CR is dropped.
    - Other non-LF bytes are stored while length<LINE_MAX. Bytes beyond that are discarded and the sticky `ovf` flag is set.
    - A frame_err byte is discarded and sets the sticky `bad` flag.
    - LF → MATCH.
    - No byte for TIMEOUT cycles → clear the buffer and flags, go to IDLE. Nothing is reported.
  - **MATCH**: one cycle, classify with this priority:
    1. ovf → OVERFLOW
    2. bad → OTHER
    3. exact text "OK" → OK
    4. "ERROR" → ERROR
    5. "RING" → RING
    6. otherwise OTHER

    Comparison is exact-length and case-sensitive. Then go to REPORT.
  - **REPORT**:
    - resp_valid=1 and resp_code is held stable.
    - On resp_ack=1: resp_valid=0, resp_code=0, resp_overrun=0, buffer cleared, go to IDLE.
    - Any byte_valid while in REPORT is dropped and sets an internal overrun flag. That flag appears on resp_overrun of the *next* report, then clears.
- line_busy = (state==RECV).
- Widths: length counter is $clog2(LINE_MAX+1) bits. Timer is 28 bits, reloaded on every byte_valid and saturating at 0.

## Timing
- LF byte_valid at cycle N → MATCH at N+1 → resp_valid=1 at N+2.
- '>' byte_valid at N in IDLE → resp_valid=1 at N+1.
- resp_ack sampled at edge M → resp_valid=0 at M+1. The earliest next byte is accepted at M+1.
- resp_ack while resp_valid=0 is ignored.
- byte_valid and resp_ack in the same cycle: the byte is dropped (counts as overrun) and the ack is honoured.
- Reset low mid-frame or mid-line: the next clock aborts reception, clears all state and outputs, and the partial byte is lost.
- Stop-bit sample to byte_valid: 1 clock.

## Structure
- Shared package `comunicaciones_pkg`:
  - Response-code localparams RESP_NONE … RESP_OVERFLOW.
  - ASCII constants CR, LF, PROMPT.
  - Baud defines (single source shared with the sender).
- Sub-module `uart_rx` (BAUD parameter; ports clk, rstn, rx, data, valid, frame_err) mirrors the `uart_tx` interface.
- Match strings are hard-coded comparators. No ROM is needed.

## Test plan
- "OK\r\n" at 115200 (BAUD=434) → resp_valid 2 clocks after the LF byte_valid, resp_code=1; ack → resp_valid=0 next cycle.
- "\r\nERROR\r\n" → the empty first line is ignored; a single report with resp_code=2.
- Single byte 0x3E, no LF → resp_code=3 one cycle after byte_valid.
- 20 × 'A' then "\r\n" with LINE_MAX=16 → resp_code=6. Then "RING\r\n" acked normally → resp_code=4.
- "OK\r\n" followed by "OK\r\n" without ack → first report held with code 1. After ack, the next line "RING\r\n" reports code 4 with resp_overrun=1.
- Additional cases:
  - "OK" then silence > TIMEOUT (reduced to 1000 in sim) → no report, line_busy falls.
  - Byte with stop bit 0 inside "OK" → resp_code=5.
  - rst low mid-byte → all outputs 0 next cycle.
